// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - requester and memory signal bundle for the unified memory arbiter
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          if_err;
    logic [DW-1:0] if_rdata;
    // data access port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic          d_err;
    logic [DW-1:0] d_rdata;
    // debug / loader port
    logic          g_req;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_ack;
    logic          g_err;
    logic [DW-1:0] g_rdata;
    // memory command / completion
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic [DW-1:0] m_rdata;
    // status
    logic          busy;
    logic [1:0]    owner;

    // arbiter side
    modport slave (
        input  if_req, if_addr,
        output if_ack, if_err, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_err, d_rdata,
        input  g_req, g_we, g_addr, g_wdata,
        output g_ack, g_err, g_rdata,
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_rdata,
        output busy, owner
    );

    // requesters and memory side
    modport master (
        output if_req, if_addr,
        input  if_ack, if_err, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_err, d_rdata,
        output g_req, g_we, g_addr, g_wdata,
        input  g_ack, g_err, g_rdata,
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - three-way arbiter for a single-port variable-latency word memory
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_dbg;

    logic          any_req;
    logic          cpu_first;
    logic [1:0]    grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          misaligned;
    logic          timeout;
    logic          fin;
    logic          fin_err;
    logic [DW-1:0] fin_rdata;
    logic [1:0]    fin_owner;

    // Winner selection: debug normally wins, but after a debug grant the CPU gets the next turn.
    always_comb begin
        any_req   = bus.g_req | bus.d_req | bus.if_req;
        cpu_first = last_dbg & (bus.d_req | bus.if_req);
        grant     = 2'd0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (bus.g_req && !cpu_first) begin
            grant     = 2'd3;
            sel_we    = bus.g_we;
            sel_addr  = bus.g_addr;
            sel_wdata = bus.g_wdata;
        end else if (bus.d_req) begin
            grant     = 2'd2;
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end else if (bus.if_req) begin
            grant     = 2'd1;
            sel_addr  = bus.if_addr;
        end
        misaligned = (sel_addr[1:0] != 2'b00);
    end

    // Decide whether the current edge completes a transaction and with what result.
    // A memory ack in the final allowed cycle beats the timeout.
    always_comb begin
        timeout   = (cnt == CW'(TIMEOUT - 1));
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
        fin_owner = bus.owner;
        case (state)
            IDLE: begin
                if (any_req && misaligned) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    fin_owner = grant;
                end
            end
            BUS: begin
                if (bus.m_ack) begin
                    fin       = 1'b1;
                    fin_rdata = bus.m_rdata;
                end else if (timeout) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Transaction sequencer; every output is a register so acks appear in the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_dbg     <= 1'b0;
            bus.owner    <= 2'd0;
            bus.busy     <= 1'b0;
            bus.m_req    <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.if_ack   <= 1'b0;
            bus.if_err   <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_ack    <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.d_rdata  <= '0;
            bus.g_ack    <= 1'b0;
            bus.g_err    <= 1'b0;
            bus.g_rdata  <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.g_ack  <= 1'b0;
            if (fin) begin
                case (fin_owner)
                    2'd1: begin
                        bus.if_ack   <= 1'b1;
                        bus.if_err   <= fin_err;
                        bus.if_rdata <= fin_rdata;
                    end
                    2'd2: begin
                        bus.d_ack    <= 1'b1;
                        bus.d_err    <= fin_err;
                        bus.d_rdata  <= fin_rdata;
                    end
                    2'd3: begin
                        bus.g_ack    <= 1'b1;
                        bus.g_err    <= fin_err;
                        bus.g_rdata  <= fin_rdata;
                    end
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.owner   <= grant;
                        bus.busy    <= 1'b1;
                        last_dbg    <= (grant == 2'd3);
                        bus.m_we    <= sel_we;
                        bus.m_addr  <= sel_addr;
                        bus.m_wdata <= sel_wdata;
                        cnt         <= '0;
                        if (misaligned) begin
                            state <= RESP;
                        end else begin
                            state     <= BUS;
                            bus.m_req <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (bus.m_ack || timeout) begin
                        bus.m_req <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    bus.owner <= 2'd0;
                    bus.busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;
        logic [31:0] mdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_mreq;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] w, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        case (w)
            2'd1: begin bus.if_req = v; bus.if_addr = addr; end
            2'd2: begin bus.d_req = v; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; end
            2'd3: begin bus.g_req = v; bus.g_we = we; bus.g_addr = addr; bus.g_wdata = wdata; end
            default: ;
        endcase
    endtask

    function automatic logic ack_of(input logic [1:0] w);
        case (w)
            2'd1: return bus.if_ack;
            2'd2: return bus.d_ack;
            2'd3: return bus.g_ack;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic err_of(input logic [1:0] w);
        case (w)
            2'd1: return bus.if_err;
            2'd2: return bus.d_err;
            2'd3: return bus.g_err;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rdata_of(input logic [1:0] w);
        case (w)
            2'd1: return bus.if_rdata;
            2'd2: return bus.d_rdata;
            2'd3: return bus.g_rdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic other_ack(input logic [1:0] w);
        return (bus.if_ack && w != 2'd1) || (bus.d_ack && w != 2'd2) || (bus.g_ack && w != 2'd3);
    endfunction

    // One isolated transaction with a memory that acks in BUS cycle k (k=0: never).
    task automatic run_vec(input vec_t v);
        int lat = -1;
        int mreq_n = 0;
        int bcnt = 0;
        int others = 0;
        @(negedge clk);
        set_req(v.who, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("owner_granted", 64'(bus.owner), 64'(v.who));
                chk("busy_granted", 64'(bus.busy), 64'd1);
            end
            if (other_ack(v.who)) others++;
            if (bus.m_req) begin
                mreq_n++;
                bcnt++;
                if (bcnt == 1) begin
                    chk("m_addr", 64'(bus.m_addr), 64'(v.addr));
                    chk("m_we", 64'(bus.m_we), 64'(v.we));
                    chk("m_wdata", 64'(bus.m_wdata), (v.who == 2'd1) ? 64'd0 : 64'(v.wdata));
                end
                bus.m_ack   = (bcnt == v.k);
                bus.m_rdata = (bcnt == v.k) ? v.mdata : 32'h0BAD_0BAD;
            end else begin
                bus.m_ack = 1'b0;
            end
            if (ack_of(v.who)) begin
                lat = c;
                chk("resp_err", 64'(err_of(v.who)), 64'(v.exp_err));
                chk("resp_rdata", 64'(rdata_of(v.who)), 64'(v.exp_rdata));
                set_req(v.who, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("m_req_cycles", 64'(mreq_n), 64'(v.exp_mreq));
        chk("no_foreign_ack", 64'(others), 64'd0);
        set_req(v.who, 1'b0, v.we, v.addr, v.wdata);
        bus.m_ack = 1'b0;
        @(negedge clk);
        chk("ack_single_pulse", 64'(ack_of(v.who)), 64'd0);
        chk("owner_idle", 64'(bus.owner), 64'd0);
        chk("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    // Contention run with a zero-wait memory; records the owner at each new grant.
    task automatic arb_run(input logic g, input logic d, input logic f, input logic hold,
                           input int n, input logic [1:0] e0, input logic [1:0] e1,
                           input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] ex[4];
        logic [1:0] prev = 2'd0;
        int got = 0;
        int last_c = 0;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        @(negedge clk);
        set_req(2'd3, g, 1'b1, 32'h0000_0040, 32'h0000_0011);
        set_req(2'd2, d, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        set_req(2'd1, f, 1'b0, 32'h0000_000C, 32'h0);
        for (int c = 1; c <= 60 && got < n; c++) begin
            @(negedge clk);
            bus.m_ack   = bus.m_req;
            bus.m_rdata = 32'h5000_0000 + 32'(c);
            if (bus.owner != 2'd0 && prev == 2'd0) begin
                chk("grant_order", 64'(bus.owner), 64'(ex[got]));
                if (got > 0) chk("grant_gap", 64'(c - last_c), 64'd3);
                if (bus.owner == 2'd2) begin
                    chk("data_m_we", 64'(bus.m_we), 64'd1);
                    chk("data_m_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
                end
                last_c = c;
                got++;
            end
            prev = bus.owner;
            if (!hold) begin
                if (bus.g_ack) bus.g_req = 1'b0;
                if (bus.d_ack) bus.d_req = 1'b0;
                if (bus.if_ack) bus.if_req = 1'b0;
            end
        end
        chk("grant_count", 64'(got), 64'(n));
        bus.g_req = 1'b0;
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            bus.m_ack = bus.m_req;
        end
        bus.m_ack = 1'b0;
        @(negedge clk);
        chk("arb_idle_after", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int bcnt;
        int lat;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.g_req = 0; bus.g_we = 0; bus.g_addr = 0; bus.g_wdata = 0;
        bus.m_ack = 0; bus.m_rdata = 0;

        //             who   we    addr          wdata         k   mdata         err   rdata         lat mreq
        vecs[0] = '{2'd1, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 1,  32'h2002_0001, 1'b0, 32'h2002_0001, 2,  1};
        vecs[1] = '{2'd2, 1'b0, 32'h0000_0100, 32'h0,         3,  32'h1234_5678, 1'b0, 32'h1234_5678, 4,  3};
        vecs[2] = '{2'd2, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1,  32'h0000_A5A5, 1'b0, 32'h0000_A5A5, 2,  1};
        vecs[3] = '{2'd3, 1'b1, 32'h0000_0020, 32'h0BEE_F00D, 2,  32'h0000_0000, 1'b0, 32'h0000_0000, 3,  2};
        vecs[4] = '{2'd3, 1'b0, 32'h0000_0006, 32'h0,         1,  32'h9999_9999, 1'b1, 32'h0000_0000, 1,  0};
        vecs[5] = '{2'd2, 1'b0, 32'h0000_0200, 32'h0,         0,  32'h0,         1'b1, 32'h0000_0000, 16, 15};
        vecs[6] = '{2'd1, 1'b0, 32'h0000_0300, 32'h0,         15, 32'h0000_CAFE, 1'b0, 32'h0000_CAFE, 16, 15};
        vecs[7] = '{2'd2, 1'b0, 32'h0000_0101, 32'h0,         1,  32'h7777_7777, 1'b1, 32'h0000_0000, 1,  0};

        repeat (3) @(negedge clk);
        chk("rst_m_req", 64'(bus.m_req), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_owner", 64'(bus.owner), 64'd0);
        chk("rst_acks", 64'({bus.if_ack, bus.d_ack, bus.g_ack}), 64'd0);
        chk("rst_rdata", 64'(bus.if_rdata | bus.d_rdata | bus.g_rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (i == 4) chk("if_rdata_held", 64'(bus.if_rdata), 64'h2002_0001);
            run_vec(vecs[i]);
            if (vecs[i].k == 0) begin
                bus.m_ack = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("stray_ack_ignored", 64'({bus.if_ack, bus.d_ack, bus.g_ack, bus.busy}), 64'd0);
                end
                bus.m_ack = 1'b0;
                chk("timeout_err_held", 64'(bus.d_err), 64'd1);
            end
        end

        // data and fetch requested together: data first, fetch after an IDLE cycle
        arb_run(1'b0, 1'b1, 1'b1, 1'b0, 2, 2'd2, 2'd1, 2'd0, 2'd0);
        // debug and data held continuously: strict alternation starting with debug
        arb_run(1'b1, 1'b1, 1'b0, 1'b1, 4, 2'd3, 2'd2, 2'd3, 2'd2);

        // reset in the third wait cycle of a fetch, then the still-pending fetch is served
        @(negedge clk);
        set_req(2'd1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        bcnt = 0;
        for (int c = 0; c < 10 && bcnt < 3; c++) begin
            @(negedge clk);
            bus.m_ack = 1'b0;
            if (bus.m_req) bcnt++;
        end
        chk("pre_reset_wait", 64'(bcnt), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_m_req", 64'(bus.m_req), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_owner", 64'(bus.owner), 64'd0);
        chk("async_rst_acks", 64'({bus.if_ack, bus.d_ack, bus.g_ack}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = -1;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            bus.m_ack   = bus.m_req;
            bus.m_rdata = 32'h7777_0010;
            if (bus.if_ack) begin
                lat = c;
                chk("post_reset_rdata", 64'(bus.if_rdata), 64'h7777_0010);
                chk("post_reset_err", 64'(bus.if_err), 64'd0);
                bus.if_req = 1'b0;
            end
        end
        chk("post_reset_latency", 64'(lat), 64'd2);
        bus.m_ack = 1'b0;
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
